// File: rtl/stim_bus_arb.sv
// Round-robin arbiter that shares one stimulus bus between N_REQ requesters.
// Each granted word stays on the bus for HOLD sink-accepted beats.
module stim_bus_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic                     bus_rdy,
  output logic [N_REQ-1:0]         gnt,
  output logic [DW-1:0]            bus_a,
  output logic                     bus_vld,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [DW-1:0]   bus_a_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic            bus_vld_nxt;
  logic [IW-1:0]   owner_nxt;
  logic            busy_nxt;

  logic [N_REQ-1:0] elig_c;
  logic             any_c;
  logic [IW-1:0]    win_c;
  logic             load_c;
  logic [DW-1:0]    words [N_REQ];

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_words
    assign words[i] = req_data[i*DW +: DW];
  end

  // A requester is never re-granted during its own grant cycle.
  assign elig_c = req & ~gnt;

  // Search downward so the offset closest to last+1 is assigned last and wins.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      if (elig_c[IW'((int'(last) + k) % int'(N_REQ))]) begin
        any_c = 1'b1;
        win_c = IW'((int'(last) + k) % int'(N_REQ));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= IW'(N_REQ - 1);
      bus_a   <= '0;
      gnt     <= '0;
      bus_vld <= 1'b0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      bus_a   <= bus_a_nxt;
      gnt     <= gnt_nxt;
      bus_vld <= bus_vld_nxt;
      owner   <= owner_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last;
    bus_a_nxt   = bus_a;
    gnt_nxt     = '0;
    bus_vld_nxt = bus_vld;
    owner_nxt   = owner;
    busy_nxt    = busy;
    load_c      = 1'b0;

    case (state)
      IDLE: begin
        if (any_c) load_c = 1'b1;
      end
      DRIVE: begin
        if (bus_rdy) begin
          if (cnt == CW'(1)) begin
            // Final beat: hand over without a bubble, or release the bus.
            if (any_c) begin
              load_c = 1'b1;
            end else begin
              state_nxt   = IDLE;
              cnt_nxt     = '0;
              bus_vld_nxt = 1'b0;
              busy_nxt    = 1'b0;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_c) begin
      state_nxt   = DRIVE;
      cnt_nxt     = CW'(HOLD);
      last_nxt    = win_c;
      owner_nxt   = win_c;
      bus_a_nxt   = words[win_c];
      gnt_nxt     = N_REQ'(1) << win_c;
      bus_vld_nxt = 1'b1;
      busy_nxt    = 1'b1;
    end
  end

endmodule
